prog_loader: RTL
================

PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter Psize, default 4: program memory address width; memory depth 2^Psize words.
REQ-002 Parameter Csize, default 11: control word width; bytes per word W = ceil(Csize/8), so W=2 at default.
REQ-003 The block SHALL use one clock and one asynchronous, active-high reset. Ports: clk and reset.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 start  input  1  one-cycle request to begin a load.
REQ-007 rxData  input  8  incoming stream byte.
REQ-008 rxValid  input  1  rxData holds a valid byte.
REQ-009 rxReady  output  1  loader accepts a byte this cycle.
REQ-010 wrEn  output  1  program memory write strobe.
REQ-011 wrAddr  output  Psize  program memory write address.
REQ-012 wrData  output  Csize  control word to write.
REQ-013 busy  output  1  load in progress; processor fetch SHALL be held while busy is high.
REQ-014 done  output  1  load completed with a good checksum.
REQ-015 error  output  1  load aborted, either for a bad count or a checksum mismatch.

Function
REQ-016 A byte SHALL be accepted on a rising clk edge where rxValid and rxReady are both high; no other byte is consumed.
REQ-017 The stream format SHALL be: count byte N, then N words of W bytes each, least-significant byte first, then one checksum byte.
REQ-018 Data bits of a word above Csize-1 in the final byte SHALL be ignored.
REQ-019 The loader SHALL implement the states IDLE, COUNT, DATA, CHECK, DONE and ERR.
REQ-020 IDLE: start moves to COUNT and clears done and error. rxReady is low.
REQ-021 COUNT: rxReady is high. On accept, N=0 or N>2^Psize moves to ERR. Otherwise N is latched, the word address is cleared to 0 and the state moves to DATA.
REQ-022 DATA: rxReady is high. Each accepted byte is shifted into the word register and added, mod 256, to the checksum accumulator, which is cleared on leaving IDLE.
REQ-023 On acceptance of the W-th byte of a word, wrEn SHALL pulse high for exactly the next cycle, with wrAddr equal to the word index and wrData equal to the assembled word.
REQ-024 After the N-th word write, the state SHALL move to CHECK. Otherwise the word index increments.
REQ-025 The write latency SHALL be exactly 1 cycle from acceptance of the last byte of a word to wrEn high.
REQ-026 CHECK: rxReady is high. On accept, a byte equal to the accumulator moves to DONE, and any other value moves to ERR.
REQ-027 The count byte and the checksum byte SHALL NOT be included in the checksum.
REQ-028 DONE and ERR: done or error respectively is held high and rxReady is low. start returns to COUNT as in REQ-020.
REQ-029 busy SHALL be high exactly in COUNT, DATA and CHECK.
REQ-030 start asserted while busy SHALL be ignored.
REQ-031 wrAddr SHALL never exceed N-1. With N=2^Psize, the index reaches 2^Psize-1, then the state leaves DATA without wrapping or writing address 0 again.
REQ-032 rxValid gaps of any length SHALL stall the loader without changing state or the accumulator.

Reset
REQ-033 reset SHALL force state IDLE immediately, independent of clk.
REQ-034 While reset is high, rxReady, wrEn, busy, done and error SHALL be 0, and wrAddr, wrData, the word register, the byte counter and the accumulator SHALL be 0.
REQ-035 Reset mid-load SHALL abandon the load; words already written remain in memory, and no further write occurs.

Structure
REQ-036 The state enumeration and the constants BYTE_W=8 and the checksum width SHALL live in the shared definitions package.
REQ-037 The block SHALL be a single module with no sub-module; byte assembly and checksum are inline registers.

Verification
REQ-038 Stream 02,34,05,12,03,4E after start -> writes addr0=0x534 and addr1=0x312; done=1, error=0, busy falls after the checksum byte.
REQ-039 Same stream with the checksum byte 4F -> both writes still occur; error=1, done=0.
REQ-040 Count byte 00, and separately count 11h at Psize=4 -> ERR immediately, no wrEn pulse, rxReady low afterwards.
REQ-041 N=16 with data words i=0..15 -> 16 writes at addresses 0..15 in order; no write to address 0 after address 15; done=1.
REQ-042 Stream from REQ-038 with rxValid toggled randomly, start pulsed mid-load -> identical write sequence and result as REQ-038.
REQ-043 reset asserted between the two bytes of word 1 -> all outputs 0 at once, no wrEn pulse; a new start with the REQ-038 stream then loads correctly.

Source files
------------

// File: rtl/prog_loader_pkg.sv
// -----------------------------------------------------------------------------
// prog_loader_pkg
// Shared definitions for the program loader: FSM state encoding, byte and
// checksum widths, and a helper to derive the number of stream bytes that
// make up one control word.
// -----------------------------------------------------------------------------
package prog_loader_pkg;

  localparam int BYTE_W = 8;
  localparam int CSUM_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    COUNT,
    DATA,
    CHECK,
    DONE,
    ERR
  } state_e;

  // Bytes needed to carry a control word of the given width.
  function automatic int bytes_per_word(input int csize);
    return (csize + BYTE_W - 1) / BYTE_W;
  endfunction

endpackage

// File: rtl/prog_loader.sv
// -----------------------------------------------------------------------------
// prog_loader
// Loads a program memory from a byte stream: count byte N, then N words of
// W bytes (LSB first), then an 8-bit additive checksum over the data bytes.
// Each completed word is written one cycle after its last byte is accepted.
//
// Ports
//   clk      rising-edge clock
//   reset    asynchronous active-high reset
//   start    one-cycle request to begin a load (ignored while busy)
//   rxData   incoming stream byte
//   rxValid  rxData holds a valid byte
//   rxReady  loader accepts a byte this cycle
//   wrEn     program memory write strobe (one-cycle pulse)
//   wrAddr   program memory write address (word index)
//   wrData   control word to write
//   busy     load in progress (COUNT, DATA, CHECK)
//   done     load completed with a good checksum
//   error    load aborted (bad count or checksum mismatch)
// -----------------------------------------------------------------------------
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int Psize = 4,
  parameter int Csize = 11
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [7:0]       rxData,
  input  logic             rxValid,
  output logic             rxReady,
  output logic             wrEn,
  output logic [Psize-1:0] wrAddr,
  output logic [Csize-1:0] wrData,
  output logic             busy,
  output logic             done,
  output logic             error
);

  localparam int W         = bytes_per_word(Csize);
  localparam int WORD_BITS = W * BYTE_W;
  localparam int BCNT_W    = (W > 1) ? $clog2(W) : 1;
  // The count can be 2^Psize, which needs one bit more than an address.
  localparam int N_W       = Psize + 1;

  state_e                 state_q, state_d;
  logic [N_W-1:0]         n_q, n_d;
  logic [Psize-1:0]       idx_q, idx_d;
  logic [BCNT_W-1:0]      bcnt_q, bcnt_d;
  logic [WORD_BITS-1:0]   word_q, word_d;
  logic [CSUM_W-1:0]      acc_q, acc_d;
  logic                   wr_en_q, wr_en_d;
  logic [Psize-1:0]       wr_addr_q, wr_addr_d;
  logic [Csize-1:0]       wr_data_q, wr_data_d;

  logic                   accept;
  logic                   last_byte;
  logic                   last_word;
  logic                   bad_count;
  logic [WORD_BITS-1:0]   word_next;
  logic [WORD_BITS+BYTE_W-1:0] shift_in;

  assign busy    = (state_q == COUNT) || (state_q == DATA) || (state_q == CHECK);
  assign rxReady = busy;
  assign done    = (state_q == DONE);
  assign error   = (state_q == ERR);
  assign wrEn    = wr_en_q;
  assign wrAddr  = wr_addr_q;
  assign wrData  = wr_data_q;

  assign accept    = rxValid && rxReady;
  // New bytes enter at the top and move down, so after W bytes the first
  // (least significant) byte sits at bit 0.
  assign shift_in  = {rxData, word_q};
  assign word_next = shift_in[WORD_BITS+BYTE_W-1:BYTE_W];
  assign last_byte = (bcnt_q == BCNT_W'(W - 1));
  assign last_word = (idx_q == Psize'(n_q - N_W'(1)));
  assign bad_count = (rxData == 8'd0) || (int'(rxData) > (1 << Psize));

  // NOTE: every variable gets a default before the case so no path leaves
  // it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_d   = state_q;
    n_d       = n_q;
    idx_d     = idx_q;
    bcnt_d    = bcnt_q;
    word_d    = word_q;
    acc_d     = acc_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;

    unique case (state_q)
      IDLE, DONE, ERR: begin
        if (start) begin
          state_d = COUNT;
          acc_d   = '0;
          bcnt_d  = '0;
          word_d  = '0;
        end
      end

      COUNT: begin
        if (accept) begin
          if (bad_count) begin
            state_d = ERR;
          end else begin
            n_d     = N_W'(rxData);
            idx_d   = '0;
            state_d = DATA;
          end
        end
      end

      DATA: begin
        if (accept) begin
          word_d = word_next;
          acc_d  = acc_q + CSUM_W'(rxData);
          if (last_byte) begin
            bcnt_d    = '0;
            wr_en_d   = 1'b1;
            wr_addr_d = idx_q;
            // Bits above Csize-1 in the final byte are dropped here.
            wr_data_d = word_next[Csize-1:0];
            if (last_word) begin
              state_d = CHECK;
            end else begin
              idx_d = idx_q + Psize'(1);
            end
          end else begin
            bcnt_d = bcnt_q + BCNT_W'(1);
          end
        end
      end

      CHECK: begin
        if (accept) begin
          state_d = (CSUM_W'(rxData) == acc_q) ? DONE : ERR;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of every other flop.
  // NOTE: every register, including the word assembly register and the
  // checksum, is reset so outputs and internal state are 0 while reset is high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      n_q       <= '0;
      idx_q     <= '0;
      bcnt_q    <= '0;
      word_q    <= '0;
      acc_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      n_q       <= n_d;
      idx_q     <= idx_d;
      bcnt_q    <= bcnt_d;
      word_q    <= word_d;
      acc_q     <= acc_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

endmodule
